pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_pkg.sv | 7 +
 rtl/pwm_core.sv | 27 ++
 rtl/pwm_ramp_ctrl.sv | 93 +++++++++
 tb/tb_pwm_ramp_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type and default sizing for pwm_ramp_ctrl
package pwm_pkg;
  typedef enum logic {IDLE, RAMP} state_t;
  localparam int DW_DEF = 8;
  localparam int PRE_MIN_DEF = 4;
  localparam int RATE_W = 3;
endpackage

// File: rtl/pwm_core.sv
// pwm_core: free-running PWM counter with registered duty comparator
// Ports: clk, rst_n (async active-low), ena (run/freeze), duty (compare value), pwm_out (registered waveform)
module pwm_core #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [DW-1:0] duty,
  output logic          pwm_out
);
  logic [DW-1:0] cnt_q, cnt_d;
  logic pwm_q, pwm_d;
  always_comb begin
    cnt_d = ena ? cnt_q + DW'(1) : cnt_q;
    pwm_d = ena && (cnt_q < duty);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  assign pwm_out = pwm_q;
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: target-tracking PWM duty controller with optional soft-start ramp
// Ports: clk, rst_n (async active-low), ena (run/park), rate (ramp speed),
//   tgt_valid/tgt_duty/tgt_ready (target handshake), duty (applied duty), busy (ramping),
//   done (one-cycle pulse when duty reaches target), pwm_out (registered PWM)
// Build option: PWM_SOFTSTART_EN enables the prescaled 1-LSB ramp; otherwise targets apply immediately.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int PRE_MIN = PRE_MIN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [RATE_W-1:0] rate,
  input  logic              tgt_valid,
  input  logic [DW-1:0]     tgt_duty,
  output logic              tgt_ready,
  output logic [DW-1:0]     duty,
  output logic              busy,
  output logic              done,
  output logic              pwm_out
);
  state_t state_q, state_d;
  logic [DW-1:0] duty_q, duty_d, tgt_q, tgt_d;
  logic done_q, done_d, acc;
  assign tgt_ready = ena && state_q == IDLE;
  assign acc = tgt_valid && tgt_ready;
`ifdef PWM_SOFTSTART_EN
  localparam int PW = (1 << RATE_W) - 1 + PRE_MIN;
  logic [PW-1:0] pre_q, pre_d, mask;
  logic tick;
  always_comb begin
    // tick when the low (rate+PRE_MIN) prescaler bits are all ones
    mask = ~({PW{1'b1}} << (rate + PRE_MIN));
    tick = (pre_q & mask) == mask;
    pre_d = ena ? pre_q + PW'(1) : pre_q;
    state_d = state_q;
    duty_d = duty_q;
    tgt_d = tgt_q;
    done_d = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      tgt_d = duty_q;
    end else if (state_q == IDLE) begin
      if (acc) begin
        tgt_d = tgt_duty;
        state_d = tgt_duty != duty_q ? RAMP : IDLE;
        done_d = tgt_duty == duty_q;
      end
    end else if (tick) begin
      duty_d = duty_q < tgt_q ? duty_q + DW'(1) : duty_q - DW'(1);
      state_d = duty_d == tgt_q ? IDLE : RAMP;
      done_d = duty_d == tgt_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre_q <= '0;
    else pre_q <= pre_d;
  assign busy = state_q == RAMP;
`else
  always_comb begin
    state_d = IDLE;
    duty_d = acc ? tgt_duty : duty_q;
    tgt_d = !ena ? duty_q : acc ? tgt_duty : tgt_q;
    done_d = acc;
  end
  assign busy = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{rate, tgt_q, PRE_MIN > 0};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q <= '0;
      tgt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      tgt_q <= tgt_d;
      done_q <= done_d;
    end
  assign duty = duty_q;
  assign done = done_q;
  pwm_core #(.DW(DW)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .duty(duty_q),
    .pwm_out(pwm_out)
  );
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed self-checking bench with a done/duty scoreboard
module tb_pwm_ramp_ctrl;
  logic clk = 1'b0;
  logic rst_n, ena, tgt_valid, tgt_ready, busy, done, pwm_out;
  logic [2:0] rate;
  logic [7:0] tgt_duty, duty;
  int total = 0;
  int bad = 0;
  int busy_seen = 0;
  logic [7:0] exp_q[$];

  pwm_ramp_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rate(rate),
    .tgt_valid(tgt_valid),
    .tgt_duty(tgt_duty),
    .tgt_ready(tgt_ready),
    .duty(duty),
    .busy(busy),
    .done(done),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen++;
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) check("done_unexpected", 32'(exp_q.size()), 1);
      else check("done_duty", 32'(duty), 32'(exp_q.pop_front()));
    end
  end

  task automatic offer(input logic [7:0] t);
    for (int i = 0; i < 200 && !tgt_ready; i++) @(negedge clk);
    check("ready_wait", 32'(tgt_ready), 1);
    tgt_valid = 1'b1;
    tgt_duty = t;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic pwm_count(input int exp);
    int n = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) n++;
      @(negedge clk);
    end
    check("pwm_high_count", 32'(n), 32'(exp));
  endtask

  task automatic wait_duty(input logic [7:0] v);
    for (int i = 0; i < 4000 && duty !== v; i++) @(negedge clk);
    check("wait_duty", 32'(duty), 32'(v));
  endtask

`ifdef PWM_SOFTSTART_EN
  task automatic ramp(input logic [7:0] t, input logic [2:0] r, input int steps);
    int gap = 1 << (r + 4);
    int last = -1;
    int n = 0;
    logic [7:0] prev = duty;
    rate = r;
    exp_q.push_back(t);
    offer(t);
    for (int c = 0; c < (steps + 2) * gap; c++) begin
      check("busy", 32'(busy), 32'(duty != t));
      check("tgt_ready", 32'(tgt_ready), 32'(duty == t));
      if (duty !== prev) begin
        check("step", 32'(duty), prev < t ? 32'(prev) + 1 : 32'(prev) - 1);
        if (last >= 0) check("step_gap", 32'(c - last), 32'(gap));
        last = c;
        n++;
        prev = duty;
      end
      if (duty === t) break;
      @(negedge clk);
    end
    check("step_count", 32'(n), 32'(steps));
    repeat (gap + 2) @(negedge clk);
    check("hold_at_target", 32'(duty), 32'(t));
  endtask
`else
  task automatic apply(input logic [7:0] t);
    exp_q.push_back(t);
    offer(t);
    check("imm_duty", 32'(duty), 32'(t));
    check("imm_done", 32'(done), 1);
    check("imm_busy", 32'(busy), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    ena = 1'b0;
    rate = 3'd0;
    tgt_valid = 1'b0;
    tgt_duty = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_duty", 32'(duty), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_ready_ena0", 32'(tgt_ready), 0);
    ena = 1'b1;
    #1 check("rst_ready_ena1", 32'(tgt_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    pwm_count(0);
`ifdef PWM_SOFTSTART_EN
    ramp(8'd4, 3'd0, 4);
    ramp(8'd200, 3'd0, 196);
    ramp(8'd190, 3'd2, 10);
    ramp(8'd5, 3'd0, 185);
    rate = 3'd0;
    offer(8'd20);
    wait_duty(8'd7);
    ena = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("park_duty", 32'(duty), 7);
      check("park_pwm", 32'(pwm_out), 0);
      check("park_busy", 32'(busy), 0);
      check("park_ready", 32'(tgt_ready), 0);
    end
    ena = 1'b1;
    ramp(8'd12, 3'd0, 5);
    ramp(8'd255, 3'd0, 243);
    pwm_count(255);
    offer(8'd100);
    wait_duty(8'd250);
    check("mid_ramp_busy", 32'(busy), 1);
`else
    apply(8'd128);
    apply(8'd255);
    pwm_count(255);
    ena = 1'b0;
    tgt_valid = 1'b1;
    tgt_duty = 8'd9;
    repeat (5) begin
      @(negedge clk);
      check("park_duty", 32'(duty), 255);
      check("park_pwm", 32'(pwm_out), 0);
      check("park_ready", 32'(tgt_ready), 0);
    end
    exp_q.push_back(8'd9);
    ena = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    check("resume_accept", 32'(duty), 9);
    apply(8'd9);
    apply(8'd77);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_duty", 32'(duty), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_pwm", 32'(pwm_out), 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_duty", 32'(duty), 0);
    check("post_rst_ready", 32'(tgt_ready), 1);
    check("sb_empty", 32'(exp_q.size()), 0);
`ifdef PWM_SOFTSTART_EN
    check("busy_seen", 32'(busy_seen != 0), 1);
`else
    check("busy_never", 32'(busy_seen), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
